rr_decoder_select: RTL and testbench
====================================

Name: rr_decoder_select

Overview:
- Round-robin select generator sitting directly upstream of the 2-to-4 decoder (Decoder2_4).
- Arbitrates four request lines and drives the decoder's 2-bit select `w` and active-low enable `e`, so at most one decoder output line is asserted at a time.
- Grants are held for a bounded number of cycles, and there is a guaranteed one-cycle break between successive grants.

Parameters:
- MAX_HOLD, 8: maximum cycles a single grant is held before forced release. Legal range 0..255; 0 means unlimited hold.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i]=1 means channel i wants the decoder.
- done  input  1  current grantee releases its grant; sampled only in GRANT.
- w  output  2  decoder select, equal to the index of the granted channel.
- e  output  1  decoder enable, active-low: 0 means grant valid, 1 means decoder disabled.
- busy  output  1  1 while in GRANT state.
- hold_cnt  output  CNT_W  cycles elapsed in the current grant (debug/verification).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (synchronous, rst=1 at a rising edge):
  - state=IDLE, w=2'd0, e=1, busy=0, hold_cnt=0, ptr=2'd0.
  - Reset overrides every other input in the same cycle.
- All outputs are registered; no combinational path from req or done to any output.
- Internal pointer `ptr` (2 bits) is the highest-priority channel for the next arbitration. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4 (wrap 3→0).
- IDLE state:
  - e=1, busy=0, hold_cnt=0.
  - w holds the last granted index; w must not toggle while e=1.
  - If req≠0: next edge → GRANT, w=first set req bit in search order, e=0, busy=1, hold_cnt=0.
  - Latency: req seen high at edge N → e=0 after edge N+1 (one cycle).
  - If req=0: stay in IDLE.
  - done is ignored in IDLE.
- GRANT state:
  - Each edge without release: hold_cnt += 1, saturating at 2^CNT_W−1.
  - Release condition is any of:
    - done=1;
    - req[w]=0 (requester dropped);
    - MAX_HOLD≠0 and hold_cnt==MAX_HOLD−1.
  - On release, next edge: state=IDLE, e=1, busy=0, hold_cnt=0, ptr=w+1 mod 4. w is unchanged.
  - There is no back-to-back grant. Every release is followed by at least one IDLE cycle with e=1 (break-before-make for the decoder lines).
  - Simultaneous release causes (done plus timeout) count as a single release.
  - A request arriving from another channel during GRANT does not pre-empt the grant.
- Fairness:
  - A requester holding req high through a timeout release is re-granted only after every other requester that was pending at the next arbitration has been served once.
  - With all four requesting continuously, the grant order is 0,1,2,3,0,...
- Reset during GRANT: next edge gives reset values. The grant is lost; there are no partial outputs.
- Invariants:
  - e=0 if and only if busy=1.
  - hold_cnt=0 whenever e=1.
  - With e=0, req[w] was 1 at the arbitration edge.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 → w=0, e=1, busy=0, hold_cnt=0 throughout. Release rst → first grant w=0, e=0 one cycle later.
- Single requester: req=4'b0100 held, MAX_HOLD=8, done=0 → w=2, e=0 for exactly 8 cycles (hold_cnt 0..7), then e=1 for 1 cycle, then w=2, e=0 again.
- Round-robin: req=4'b1111 held, done pulsed 1 cycle after each grant → w sequence 0,1,2,3,0, with one e=1 cycle between each grant. w is stable during every e=1 cycle.
- Requester drop and wrap: grant on ch3; drop req[3] while req=4'b0011 → e=1 next cycle, then next grant w=0 (ptr wrapped 3→0), not w=1.
- Reset mid-grant: grant w=1, hold_cnt=3, assert rst for 1 cycle → w=0, e=0→1, hold_cnt=0, ptr=0. With req=4'b0011 the next grant is w=0.
- Unlimited hold: MAX_HOLD=0, req=4'b0001, no done for 300 cycles → e stays 0, hold_cnt saturates at 255, no release. Then done=1 → e=1 next cycle.

Source files
------------

// File: rtl/rr_decoder_select.sv
// rr_decoder_select
//   Round-robin select generator for a 2-to-4 decoder. Four request lines are
//   arbitrated and the winner's index is driven on the decoder select `w`,
//   with the decoder enabled by the active-low `e`. A grant is held until the
//   grantee signals done, drops its request, or the hold limit expires. Every
//   release is followed by at least one idle cycle with the decoder disabled.
//
// Parameters
//   MAX_HOLD : maximum cycles a grant is held (0 = unlimited, legal 0..255)
//   CNT_W    : hold counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   req      in   [3:0] request vector, bit i = channel i wants the decoder
//   done     in   grantee releases its grant (only looked at while granted)
//   w        out  [1:0] decoder select = granted channel index
//   e        out  decoder enable, active low (0 = grant valid)
//   busy     out  1 while a grant is active
//   hold_cnt out  [CNT_W-1:0] cycles elapsed in the current grant
module rr_decoder_select #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             done,
  output logic [1:0]       w,
  output logic             e,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter value at which the last cycle of a bounded grant is reached.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [1:0]       w_reg, w_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

  logic [1:0] pick;
  logic [1:0] idx;
  logic       any_req;
  logic       timeout;
  logic       release_now;

  // Priority search starting at ptr: walk the offsets from 3 down to 0 so the
  // last match written (smallest offset from ptr) wins.
  always_comb begin
    pick = ptr_reg;
    idx  = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_reg + 2'(k);
      if (req[idx]) begin
        pick = idx;
      end
    end
  end

  assign any_req     = |req;
  assign timeout     = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);
  assign release_now = done || !req[w_reg] || timeout;

  always_comb begin
    state_next    = state_reg;
    w_next        = w_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        // w keeps the last granted index so the select never moves while the
        // decoder is disabled.
        if (any_req) begin
          state_next = GRANT;
          w_next     = pick;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Moving the pointer past the grantee is what makes a requester that
          // keeps its line high wait for everyone else.
          state_next = IDLE;
          ptr_next   = w_reg + 2'd1;
        end else if (hold_cnt_reg != CNT_MAX) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      w_reg        <= 2'd0;
      ptr_reg      <= 2'd0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      w_reg        <= w_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Outputs are straight decodes of registered state only.
  assign w        = w_reg;
  assign busy     = (state_reg == GRANT);
  assign e        = (state_reg != GRANT);
  assign hold_cnt = hold_cnt_reg;

endmodule

// File: tb/tb_rr_decoder_select.sv
module tb_rr_decoder_select;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic       done_a, done_b;
  logic [1:0] w_a, w_b;
  logic       e_a, e_b, busy_a, busy_b;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         sel;   // 0 = bounded-hold DUT, 1 = unlimited-hold DUT
    logic [1:0] w;
    logic       e;
    logic       busy;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_decoder_select #(.MAX_HOLD(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .done(done_a),
    .w(w_a), .e(e_a), .busy(busy_a), .hold_cnt(cnt_a)
  );

  rr_decoder_select #(.MAX_HOLD(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .done(done_b),
    .w(w_b), .e(e_b), .busy(busy_b), .hold_cnt(cnt_b)
  );

  task automatic expect_a(input logic [1:0] w, input logic e, input logic [7:0] cnt, input string tag);
    exp_t x;
    x.sel = 1'b0; x.w = w; x.e = e; x.busy = ~e; x.cnt = cnt; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic expect_b(input logic [1:0] w, input logic e, input logic [7:0] cnt, input string tag);
    exp_t x;
    x.sel = 1'b1; x.w = w; x.e = e; x.busy = ~e; x.cnt = cnt; x.tag = tag;
    sb.push_back(x);
  endtask

  // Advance one clock, then compare every expectation queued for this edge.
  task automatic tick();
    exp_t x;
    logic [11:0] obs, want;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      want = {x.w, x.e, x.busy, x.cnt};
      obs  = x.sel ? {w_b, e_b, busy_b, cnt_b} : {w_a, e_a, busy_a, cnt_a};
      checks++;
      assert (obs === want)
      else begin
        errors++;
        $error("FAIL %s: got w=%0d e=%b busy=%b cnt=%0d, expected w=%0d e=%b busy=%b cnt=%0d",
               x.tag, obs[11:10], obs[9], obs[8], obs[7:0], x.w, x.e, x.busy, x.cnt);
      end
      $display("check %s: w=%0d e=%b busy=%b cnt=%0d", x.tag, obs[11:10], obs[9], obs[8], obs[7:0]);
    end
  endtask

  initial begin
    rst = 1'b1; req_a = 4'b1111; done_a = 1'b0; req_b = 4'b0000; done_b = 1'b0;
    @(negedge clk);

    // Reset held two cycles with every request high.
    expect_a(2'd0, 1'b1, 8'd0, "reset_0"); expect_b(2'd0, 1'b1, 8'd0, "reset_b"); tick();
    expect_a(2'd0, 1'b1, 8'd0, "reset_1"); tick();

    // Release reset: first grant goes to channel 0 one cycle later.
    rst = 1'b0;
    expect_a(2'd0, 1'b0, 8'd0, "first_grant"); tick();

    // Round-robin with done pulsed one cycle into each grant.
    for (int g = 0; g < 4; g++) begin
      done_a = 1'b1;
      expect_a(2'(g), 1'b1, 8'd0, "rr_break"); tick();
      done_a = 1'b0;
      expect_a(2'(g + 1), 1'b0, 8'd0, "rr_grant"); tick();
    end
    done_a = 1'b1;
    expect_a(2'd0, 1'b1, 8'd0, "rr_last_break"); tick();
    done_a = 1'b0;

    // Single requester on channel 2: bounded to 8 cycles, one-cycle break.
    req_a = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      expect_a(2'd2, 1'b0, 8'(i), "hold_run"); tick();
    end
    expect_a(2'd2, 1'b1, 8'd0, "timeout_break"); tick();
    expect_a(2'd2, 1'b0, 8'd0, "regrant_2"); tick();

    // Requester drop, then done ignored while idle; w stays put.
    req_a = 4'b0000;
    expect_a(2'd2, 1'b1, 8'd0, "drop_release"); tick();
    done_a = 1'b1;
    expect_a(2'd2, 1'b1, 8'd0, "idle_done_ignored"); tick();
    done_a = 1'b0;

    // Grant on ch3, drop it while ch0/ch1 request: pointer wraps to 0.
    req_a = 4'b1000;
    expect_a(2'd3, 1'b0, 8'd0, "grant_3"); tick();
    req_a = 4'b0011;
    expect_a(2'd3, 1'b1, 8'd0, "drop_3"); tick();
    expect_a(2'd0, 1'b0, 8'd0, "wrap_grant_0"); tick();
    done_a = 1'b1;
    expect_a(2'd0, 1'b1, 8'd0, "wrap_release"); tick();
    done_a = 1'b0;

    // Fairness: ch2 times out while ch0 waits; ch0 goes next, not ch2.
    req_a = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      expect_a(2'd2, 1'b0, 8'(i), "fair_hold"); tick();
    end
    expect_a(2'd2, 1'b1, 8'd0, "fair_break"); tick();
    expect_a(2'd0, 1'b0, 8'd0, "fair_next_0"); tick();
    done_a = 1'b1;
    expect_a(2'd0, 1'b1, 8'd0, "fair_release"); tick();
    done_a = 1'b0;

    // Reset mid-grant: ch1 granted to hold_cnt=3, then reset.
    req_a = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      expect_a(2'd1, 1'b0, 8'(i), "pre_reset_hold"); tick();
    end
    rst = 1'b1;
    expect_a(2'd0, 1'b1, 8'd0, "mid_reset"); expect_b(2'd0, 1'b1, 8'd0, "mid_reset_b"); tick();
    rst = 1'b0;
    req_a = 4'b0011;
    expect_a(2'd0, 1'b0, 8'd0, "post_reset_grant"); tick();
    req_a = 4'b0000;
    expect_a(2'd0, 1'b1, 8'd0, "post_reset_drop"); tick();

    // Unlimited hold: counter saturates, no forced release.
    req_b = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      expect_b(2'd0, 1'b0, (i > 255) ? 8'd255 : 8'(i), "unlimited_hold"); tick();
    end
    done_b = 1'b1;
    expect_b(2'd0, 1'b1, 8'd0, "unlimited_done"); tick();
    done_b = 1'b0;
    req_b = 4'b0000;
    expect_b(2'd0, 1'b1, 8'd0, "unlimited_idle"); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
